// File: rtl/fluid_pll_reset_sequencer_pkg.sv
// Shared definitions for the fluid-board PLL reset sequencer: FSM encodings and status widths.
package fluid_pll_reset_sequencer_pkg;

   localparam int LOSS_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_LOST      = 3'd5
   } state_e;

endpackage

// File: rtl/fluid_pll_reset_sequencer_sync2.sv
// Generic 2-FF synchroniser for async inputs; both flops clear to 0 on reset.
module fluid_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fluid_pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, and releases staged SoC resets; keeps sticky
// timeout / lock-loss status for the NIOS.
module fluid_pll_reset_sequencer
   import fluid_pll_reset_sequencer_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 500000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int NUM_STAGES          = 2,
   parameter int STAGE_GAP_CYCLES    = 64,
   parameter int CNT_W               = 20
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  clear_status,
   output logic                  pll_rst,
   output logic [NUM_STAGES-1:0] rst_n_out,
   output logic                  ready,
   output logic                  timeout_err,
   output logic [LOSS_CNT_W-1:0] lock_loss_count,
   output logic [2:0]            state
);

   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

   state_e                  st, st_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic                    locked_s;
   logic                    pll_rst_nxt, ready_nxt, timeout_nxt;
   logic [NUM_STAGES-1:0]   rst_n_nxt;
   logic [LOSS_CNT_W-1:0]   loss_nxt;

   fluid_sync2 #(.WIDTH(1)) u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pll_locked),
      .q       (locked_s)
   );

   always_comb begin
      st_nxt      = st;
      cnt_nxt     = cnt + 1'b1;
      pll_rst_nxt = pll_rst;
      rst_n_nxt   = rst_n_out;
      ready_nxt   = ready;
      // clear is applied before any same-cycle event so the event survives
      timeout_nxt = timeout_err & ~clear_status;
      loss_nxt    = clear_status ? '0 : lock_loss_count;
      case (st)
         ST_PLL_RST: begin
            pll_rst_nxt = 1'b1;
            if (cnt == PLL_RST_LAST) begin
               pll_rst_nxt = 1'b0;
               st_nxt      = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               st_nxt = ST_STABILIZE;
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_nxt = 1'b1;
               pll_rst_nxt = 1'b1;
               st_nxt      = ST_PLL_RST;
            end
         end
         ST_STABILIZE: begin
            if (!locked_s) begin
               st_nxt = ST_WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               rst_n_nxt = NUM_STAGES'(1);
               ready_nxt = rst_n_nxt[NUM_STAGES-1];
               st_nxt    = ready_nxt ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (st == ST_RUN) cnt_nxt = cnt;
            if (!locked_s) begin
               rst_n_nxt = '0;
               ready_nxt = 1'b0;
               loss_nxt  = (loss_nxt == {LOSS_CNT_W{1'b1}}) ? loss_nxt : loss_nxt + 1'b1;
               st_nxt    = ST_LOST;
            end else if (st == ST_RELEASE && cnt == GAP_LAST) begin
               // rst_n_out is a thermometer: its fill level is the stage index
               rst_n_nxt = (rst_n_out << 1) | NUM_STAGES'(1);
               ready_nxt = rst_n_nxt[NUM_STAGES-1];
               cnt_nxt   = '0;
               if (ready_nxt) st_nxt = ST_RUN;
            end
         end
         ST_LOST: begin
            pll_rst_nxt = 1'b1;
            st_nxt      = ST_PLL_RST;
         end
         default: begin
            st_nxt      = ST_PLL_RST;
            pll_rst_nxt = 1'b1;
            rst_n_nxt   = '0;
            ready_nxt   = 1'b0;
            timeout_nxt = 1'b0;
            loss_nxt    = '0;
         end
      endcase
      if (st_nxt != st) cnt_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st              <= ST_PLL_RST;
         cnt             <= '0;
         pll_rst         <= 1'b1;
         rst_n_out       <= '0;
         ready           <= 1'b0;
         timeout_err     <= 1'b0;
         lock_loss_count <= '0;
      end else begin
         st              <= st_nxt;
         cnt             <= cnt_nxt;
         pll_rst         <= pll_rst_nxt;
         rst_n_out       <= rst_n_nxt;
         ready           <= ready_nxt;
         timeout_err     <= timeout_nxt;
         lock_loss_count <= loss_nxt;
      end
   end

   assign state = st;

endmodule

// File: tb/tb_fluid_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues (edge, signal, value) expectations; a negedge monitor pops and checks.
module tb_fluid_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       clear_status = 1'b0;
   logic       pll_rst;
   logic [1:0] rst_n_out;
   logic       ready;
   logic       timeout_err;
   logic [7:0] lock_loss_count;
   logic [2:0] state;

   fluid_pll_reset_sequencer #(
      .PLL_RST_CYCLES      (4),
      .LOCK_TIMEOUT_CYCLES (100),
      .LOCK_STABLE_CYCLES  (8),
      .NUM_STAGES          (2),
      .STAGE_GAP_CYCLES    (4),
      .CNT_W               (20)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pll_locked      (pll_locked),
      .clear_status    (clear_status),
      .pll_rst         (pll_rst),
      .rst_n_out       (rst_n_out),
      .ready           (ready),
      .timeout_err     (timeout_err),
      .lock_loss_count (lock_loss_count),
      .state           (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int S_PR = 0, S_RN = 1, S_RDY = 2, S_TO = 3, S_LOSS = 4, S_ST = 5;

   typedef struct {
      int when;
      int sig;
      int val;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   base   = 0;

   function automatic string sig_name(input int s);
      case (s)
         S_PR:    return "pll_rst";
         S_RN:    return "rst_n_out";
         S_RDY:   return "ready";
         S_TO:    return "timeout_err";
         S_LOSS:  return "lock_loss_count";
         default: return "state";
      endcase
   endfunction

   function automatic int sample(input int s);
      case (s)
         S_PR:    return int'(pll_rst);
         S_RN:    return int'(rst_n_out);
         S_RDY:   return int'(ready);
         S_TO:    return int'(timeout_err);
         S_LOSS:  return int'(lock_loss_count);
         default: return int'(state);
      endcase
   endfunction

   function automatic void push(input int when, input int s, input int v);
      exp_t it;
      int   i;
      it.when = when;
      it.sig  = s;
      it.val  = v;
      i = q.size();
      while (i > 0 && q[i-1].when > when) i--;
      q.insert(i, it);
   endfunction

   // expectation relative to edge 0 of the current test; -1 skips a field
   function automatic void exp_e(input int e, input int pr, input int rn, input int rdy, input int st);
      if (pr  >= 0) push(base + e, S_PR,  pr);
      if (rn  >= 0) push(base + e, S_RN,  rn);
      if (rdy >= 0) push(base + e, S_RDY, rdy);
      if (st  >= 0) push(base + e, S_ST,  st);
   endfunction

   exp_t mon_it;
   int   mon_act;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].when <= cyc) begin
         mon_it  = q.pop_front();
         mon_act = sample(mon_it.sig);
         checks++;
         if (mon_it.when != cyc) begin
            errors++;
            $display("FAIL %s stale at cycle %0d (due %0d): got %0d want %0d",
                     sig_name(mon_it.sig), cyc, mon_it.when, mon_act, mon_it.val);
         end else if (mon_act != mon_it.val) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d",
                     sig_name(mon_it.sig), cyc, mon_act, mon_it.val);
         end
      end
   end

   task automatic goto(input int e);
      while (cyc < base + e) @(negedge clk);
      #1;
   endtask

   task automatic wait_state(input int s, input int lim);
      int n = 0;
      while (int'(state) != s && n < lim) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (int'(state) != s) begin
         checks++;
         errors++;
         $display("FAIL wait_state timeout: got %0d want %0d", state, s);
      end
   endtask

   // reset is held across one monitor sample, which checks the reset values
   task automatic do_reset();
      @(negedge clk);
      #1;
      reset_n      = 1'b0;
      pll_locked   = 1'b0;
      clear_status = 1'b0;
      push(cyc + 1, S_PR, 1);
      push(cyc + 1, S_RN, 0);
      push(cyc + 1, S_RDY, 0);
      push(cyc + 1, S_TO, 0);
      push(cyc + 1, S_LOSS, 0);
      push(cyc + 1, S_ST, 0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      base    = cyc + 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int n;

      // scenario 1 + 4: clean lock, release, then lock loss and relock
      do_reset();
      exp_e(0, 1, 0, 0, 0);
      exp_e(2, 1, 0, 0, 0);
      exp_e(3, 0, 0, 0, 1);
      exp_e(11, 0, 0, 0, 1);
      exp_e(12, 0, 0, 0, 2);
      exp_e(19, 0, 0, 0, 2);
      exp_e(20, 0, 1, 0, 3);
      exp_e(23, 0, 1, 0, 3);
      exp_e(24, 0, 3, 1, 4);
      exp_e(39, 0, 3, 1, 4);
      exp_e(41, 0, 3, 1, 4);
      exp_e(42, 0, 0, 0, 5);
      push(base + 42, S_LOSS, 1);
      exp_e(43, 1, 0, 0, 0);
      exp_e(46, 1, 0, 0, 0);
      exp_e(47, 0, 0, 0, 1);
      exp_e(63, 0, 0, 0, 2);
      exp_e(64, 0, 1, 0, 3);
      exp_e(67, 0, 1, 0, 3);
      exp_e(68, 0, 3, 1, 4);
      push(base + 68, S_LOSS, 1);
      goto(9);  pll_locked = 1'b1;
      goto(39); pll_locked = 1'b0;
      goto(53); pll_locked = 1'b1;
      goto(70);

      // scenario 3: 3-cycle glitch after 5 stable cycles, then scenario 6 mid-RELEASE
      do_reset();
      exp_e(16, 0, 0, 0, 2);
      exp_e(17, 0, 0, 0, 1);
      exp_e(19, 0, 0, 0, 1);
      exp_e(20, 0, 0, 0, 2);
      exp_e(27, 0, 0, 0, 2);
      exp_e(28, 0, 1, 0, 3);
      push(base + 28, S_LOSS, 0);
      goto(9);  pll_locked = 1'b1;
      goto(14); pll_locked = 1'b0;
      goto(17); pll_locked = 1'b1;
      goto(28);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      push(cyc, S_PR, 1);
      push(cyc, S_RN, 0);
      push(cyc, S_RDY, 0);
      push(cyc, S_ST, 0);

      // scenario 2: no lock, timeouts, clear behaviour
      do_reset();
      exp_e(3, 0, 0, 0, 1);
      push(base + 102, S_TO, 0);
      exp_e(102, 0, 0, 0, 1);
      exp_e(103, 1, 0, 0, 0);
      push(base + 104, S_TO, 1);
      exp_e(106, 1, 0, 0, 0);
      exp_e(107, 0, 0, 0, 1);
      exp_e(150, 0, 0, 0, 1);
      exp_e(206, 0, 0, 0, 1);
      exp_e(207, 1, 0, 0, 0);
      exp_e(210, 1, 0, 0, 0);
      exp_e(211, 0, 0, 0, 1);
      push(base + 250, S_TO, 0);
      push(base + 310, S_TO, 0);
      push(base + 311, S_TO, 1);
      exp_e(311, 1, 0, 0, 0);
      goto(249); clear_status = 1'b1;
      goto(250); clear_status = 1'b0;
      goto(310); clear_status = 1'b1;
      goto(311); clear_status = 1'b0;
      goto(312);

      // scenario 5: saturate the loss counter, then clear coincident with a loss
      do_reset();
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b1;
         wait_state(4, 100);
         pll_locked = 1'b0;
         wait_state(0, 20);
         if (i == 0 || i == 254 || i == 299)
            push(cyc + 1, S_LOSS, (i == 0) ? 1 : 255);
      end
      pll_locked = 1'b1;
      wait_state(4, 100);
      k = cyc;
      pll_locked = 1'b0;
      push(k + 2, S_LOSS, 255);
      push(k + 2, S_ST, 4);
      push(k + 3, S_LOSS, 1);
      push(k + 3, S_ST, 5);
      push(k + 3, S_RN, 0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      clear_status = 1'b1;
      @(negedge clk); #1;
      clear_status = 1'b0;

      n = 0;
      while (q.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         checks += q.size();
         errors += q.size();
         $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
